// File: rtl/comb_test_if.sv
// comb_test_if
// Pattern-delivery channel between a pattern source and comb_test_ctrl.
//   pat_valid  source -> ctrl   pattern word valid
//   pat_ready  ctrl -> source   controller accepts pattern (LOAD only)
//   pat_in     source -> ctrl   {pi_bits, pin_bits}
//   exp_in     source -> ctrl   expected response {po, out}
//   pat_last   source -> ctrl   final pattern of session, qualified by pat_valid
// Modports: master = pattern source, slave = controller.
interface comb_test_if #(
  parameter int PIN_W  = 3,
  parameter int PI_W   = 2,
  parameter int POUT_W = 3,
  parameter int PO_W   = 2
) ();
  logic                     pat_valid;
  logic                     pat_ready;
  logic [PIN_W+PI_W-1:0]    pat_in;
  logic [POUT_W+PO_W-1:0]   exp_in;
  logic                     pat_last;

  modport master (output pat_valid, pat_in, exp_in, pat_last, input pat_ready);
  modport slave  (input pat_valid, pat_in, exp_in, pat_last, output pat_ready);
endinterface

// File: rtl/comb_test_ctrl.sv
// comb_test_ctrl
// Sequential test controller for a small combinational core. Patterns arrive
// over the comb_test_if handshake; the pseudo-input part is shifted serially
// into the scan register, the core settles for one cycle, then the response
// {core_po, core_out} is captured and compared with the expected word.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   start               begin a session (IDLE only)
//   pat                 pattern channel (slave modport)
//   core_in / core_pi   drive core primary / pseudo inputs
//   core_out / core_po  core primary / pseudo outputs
//   busy, done          session in progress, one-cycle end pulse
//   pat_cnt, fail_cnt   saturating pattern and mismatch counters
//   first_fail          index of first mismatch, all-ones if none
//   sig                 response signature
// Optional build macro: COMB_TEST_SIGNATURE_EN builds a 16-bit MISR
// (x^16+x^12+x^5+1, seed 0) over captured responses; otherwise sig is 0.
//
// state   | meaning
// IDLE    | results held, waiting for start
// LOAD    | pat_ready=1, waiting for a pattern transfer
// SHIFT   | one pseudo-input bit per cycle into core_pi
// APPLY   | settle cycle, core inputs stable
// CAPTURE | compare response, update counters
// DONE    | done pulse, back to IDLE
module comb_test_ctrl #(
  parameter int PIN_W  = 3,
  parameter int PI_W   = 2,
  parameter int POUT_W = 3,
  parameter int PO_W   = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  comb_test_if.slave        pat,
  output logic [PIN_W-1:0]  core_in,
  output logic [PI_W-1:0]   core_pi,
  input  logic [POUT_W-1:0] core_out,
  input  logic [PO_W-1:0]   core_po,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [CNT_W-1:0]  pat_cnt,
  output logic [CNT_W-1:0]  first_fail,
  output logic [15:0]       sig
);
  localparam int RSP_W = POUT_W + PO_W;
  localparam int SC_W  = (PI_W > 1) ? $clog2(PI_W) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, APPLY, CAPTURE, DONE} state_t;

  state_t            state, state_nxt;
  logic [PI_W-1:0]   sbuf;
  logic [PI_W-1:0]   shift_in;
  logic [SC_W-1:0]   shift_cnt;
  logic [RSP_W-1:0]  exp_q;
  logic              last_q;
  logic [RSP_W-1:0]  rsp;
  logic              mismatch;
  logic              xfer;

  assign rsp       = {core_po, core_out};
  assign mismatch  = (rsp != exp_q);
  assign xfer      = (state == LOAD) && pat.pat_valid;
  assign pat.pat_ready = (state == LOAD);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // next scan bit enters at the MSB and walks toward bit 0
  always_comb begin
    shift_in = '0;
    shift_in[PI_W-1] = sbuf[0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (pat.pat_valid) state_nxt = (PI_W == 0) ? APPLY : SHIFT;
      SHIFT:   if (shift_cnt == '0) state_nxt = APPLY;
      APPLY:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = last_q ? DONE : LOAD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      core_in    <= '0;
      core_pi    <= '0;
      sbuf       <= '0;
      shift_cnt  <= '0;
      exp_q      <= '0;
      last_q     <= 1'b0;
      pat_cnt    <= '0;
      fail_cnt   <= '0;
      first_fail <= '1;
    end else begin
      case (state)
        IDLE: if (start) begin
          pat_cnt    <= '0;
          fail_cnt   <= '0;
          first_fail <= '1;
        end
        LOAD: if (xfer) begin
          core_in   <= pat.pat_in[PIN_W-1:0];
          sbuf      <= pat.pat_in[PIN_W+PI_W-1:PIN_W];
          exp_q     <= pat.exp_in;
          last_q    <= pat.pat_last;
          shift_cnt <= SC_W'(PI_W - 1);
        end
        SHIFT: begin
          core_pi <= (core_pi >> 1) | shift_in;
          sbuf    <= sbuf >> 1;
          if (shift_cnt != '0) shift_cnt <= shift_cnt - SC_W'(1);
        end
        CAPTURE: begin
          if (pat_cnt != '1) pat_cnt <= pat_cnt + CNT_W'(1);
          if (mismatch) begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
            // a saturated pat_cnt no longer names a real index
            if ((first_fail == '1) && (pat_cnt != '1)) first_fail <= pat_cnt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef COMB_TEST_SIGNATURE_EN
  logic [15:0] misr;
  always_ff @(posedge clk) begin
    if (!reset_n)
      misr <= '0;
    else if ((state == IDLE) && start)
      misr <= '0;
    else if (state == CAPTURE)
      misr <= {misr[14:0], 1'b0} ^ (misr[15] ? 16'h1021 : 16'h0000) ^ 16'(rsp);
  end
  assign sig = misr;
`else
  assign sig = '0;
`endif

endmodule

// File: tb/tb_comb_test_ctrl.sv
module tb_comb_test_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  core_in;
  logic [1:0]  core_pi;
  logic [2:0]  core_out;
  logic [1:0]  core_po;
  logic        busy, done;
  logic [7:0]  fail_cnt, pat_cnt, first_fail;
  logic [15:0] sig;
  int          checks = 0;
  int          failures = 0;

  comb_test_if #(.PIN_W(3), .PI_W(2), .POUT_W(3), .PO_W(2)) pat_if ();

  comb_test_ctrl #(.PIN_W(3), .PI_W(2), .POUT_W(3), .PO_W(2), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pat(pat_if),
    .core_in(core_in), .core_pi(core_pi), .core_out(core_out), .core_po(core_po),
    .busy(busy), .done(done), .fail_cnt(fail_cnt), .pat_cnt(pat_cnt),
    .first_fail(first_fail), .sig(sig)
  );

  // attached 3-in/3-out core
  assign core_out = {core_pi[1] | core_in[2], core_pi[0] | core_in[1], core_in[0]};
  assign core_po  = {core_in[1] & core_in[0], ~core_in[0]};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_session();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // transfer one pattern and walk it through SHIFT, SHIFT, APPLY, CAPTURE
  task automatic run_pattern(input logic [2:0] pin, input logic [1:0] pi,
                             input logic [4:0] expw, input logic last);
    pat_if.pat_valid = 1'b1;
    pat_if.pat_in    = {pi, pin};
    pat_if.exp_in    = expw;
    pat_if.pat_last  = last;
    tick();
    pat_if.pat_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    checks++; if (pat_if.pat_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", pat_if.pat_ready); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_busy_done got=%b%b exp=00", busy, done); end
    checks++; if (core_in !== 3'b000 || core_pi !== 2'b00) begin failures++; $display("FAIL rst_core got=%b/%b exp=000/00", core_in, core_pi); end
    checks++; if (pat_cnt !== 8'h00 || fail_cnt !== 8'h00) begin failures++; $display("FAIL rst_cnt got=%h/%h exp=00/00", pat_cnt, fail_cnt); end
    checks++; if (first_fail !== 8'hFF || sig !== 16'h0000) begin failures++; $display("FAIL rst_ff_sig got=%h/%h exp=ff/0000", first_fail, sig); end
  endtask

  task automatic test_single();
    begin_session();
    checks++; if (pat_if.pat_ready !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL single_load got=%b%b exp=11", pat_if.pat_ready, busy); end
    pat_if.pat_valid = 1'b1; pat_if.pat_in = 5'b11_011; pat_if.exp_in = 5'b10_111; pat_if.pat_last = 1'b1;
    tick();
    pat_if.pat_valid = 1'b0;
    checks++; if (core_in !== 3'b011 || pat_if.pat_ready !== 1'b0) begin failures++; $display("FAIL single_xfer got=%b/%b exp=011/0", core_in, pat_if.pat_ready); end
    tick();
    checks++; if (core_pi !== 2'b10) begin failures++; $display("FAIL single_shift1 got=%b exp=10", core_pi); end
    tick();
    checks++; if (core_pi !== 2'b11) begin failures++; $display("FAIL single_shift2 got=%b exp=11", core_pi); end
    tick();
    checks++; if (pat_cnt !== 8'h00 || done !== 1'b0 || core_pi !== 2'b11) begin failures++; $display("FAIL single_capture got=%h/%b/%b exp=00/0/11", pat_cnt, done, core_pi); end
    tick();
    checks++; if (done !== 1'b1 || pat_cnt !== 8'h01 || fail_cnt !== 8'h00 || first_fail !== 8'hFF)
      begin failures++; $display("FAIL single_done got=%b %h %h %h exp=1 01 00 ff", done, pat_cnt, fail_cnt, first_fail); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || pat_cnt !== 8'h01) begin failures++; $display("FAIL single_idle got=%b%b %h exp=00 01", done, busy, pat_cnt); end
  endtask

  task automatic test_two_patterns();
    begin_session();
    run_pattern(3'b011, 2'b11, 5'b10_111, 1'b0);
    checks++; if (pat_if.pat_ready !== 1'b1 || pat_cnt !== 8'h01 || fail_cnt !== 8'h00)
      begin failures++; $display("FAIL two_first got=%b %h %h exp=1 01 00", pat_if.pat_ready, pat_cnt, fail_cnt); end
    run_pattern(3'b000, 2'b11, 5'b01_111, 1'b1);
    checks++; if (done !== 1'b1 || pat_cnt !== 8'h02 || fail_cnt !== 8'h01 || first_fail !== 8'h01)
      begin failures++; $display("FAIL two_result got=%b %h %h %h exp=1 02 01 01", done, pat_cnt, fail_cnt, first_fail); end
`ifdef COMB_TEST_SIGNATURE_EN
    checks++; if (sig !== 16'h0020) begin failures++; $display("FAIL two_sig got=%h exp=0020", sig); end
`else
    checks++; if (sig !== 16'h0000) begin failures++; $display("FAIL two_sig got=%h exp=0000", sig); end
`endif
    repeat (3) tick();
    checks++; if (busy !== 1'b0 || pat_cnt !== 8'h02 || first_fail !== 8'h01)
      begin failures++; $display("FAIL two_hold got=%b %h %h exp=0 02 01", busy, pat_cnt, first_fail); end
  endtask

  task automatic test_stall();
    int bad;
    bad = 0;
    begin_session();
    pat_if.pat_valid = 1'b0; pat_if.pat_in = 5'b00_101; pat_if.exp_in = 5'b0; pat_if.pat_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pat_if.pat_ready !== 1'b1 || busy !== 1'b1 || core_in !== 3'b000) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL stall bad_cycles got=%0d exp=0 ready=%b core_in=%b", bad, pat_if.pat_ready, core_in); end
    run_pattern(3'b011, 2'b11, 5'b10_111, 1'b1);
    checks++; if (done !== 1'b1 || pat_cnt !== 8'h01) begin failures++; $display("FAIL stall_end got=%b %h exp=1 01", done, pat_cnt); end
    tick();
  endtask

  task automatic test_start_with_valid();
    // core_in holds 011 from the previous session
    pat_if.pat_valid = 1'b1; pat_if.pat_in = 5'b11_000; pat_if.exp_in = 5'b01_110; pat_if.pat_last = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (pat_if.pat_ready !== 1'b1 || core_in !== 3'b011) begin failures++; $display("FAIL startvalid got=%b %b exp=1 011", pat_if.pat_ready, core_in); end
    tick();
    pat_if.pat_valid = 1'b0;
    checks++; if (core_in !== 3'b000 || pat_if.pat_ready !== 1'b0) begin failures++; $display("FAIL startvalid_xfer got=%b %b exp=000 0", core_in, pat_if.pat_ready); end
    repeat (4) tick();
    checks++; if (done !== 1'b1 || pat_cnt !== 8'h01 || fail_cnt !== 8'h00) begin failures++; $display("FAIL startvalid_done got=%b %h %h exp=1 01 00", done, pat_cnt, fail_cnt); end
    tick();
  endtask

  task automatic test_reset_mid();
    begin_session();
    run_pattern(3'b011, 2'b11, 5'b10_111, 1'b0);
    pat_if.pat_valid = 1'b1; pat_if.pat_in = 5'b11_000; pat_if.exp_in = 5'b01_111; pat_if.pat_last = 1'b1;
    tick();
    pat_if.pat_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++; if (busy !== 1'b0 || pat_if.pat_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_ctl got=%b%b%b exp=000", busy, pat_if.pat_ready, done); end
    checks++; if (core_in !== 3'b000 || core_pi !== 2'b00 || pat_cnt !== 8'h00 || first_fail !== 8'hFF || sig !== 16'h0)
      begin failures++; $display("FAIL midrst_data got=%b %b %h %h %h exp=000 00 00 ff 0000", core_in, core_pi, pat_cnt, first_fail, sig); end
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_stay got=%b exp=0", busy); end
    begin_session();
    run_pattern(3'b011, 2'b11, 5'b10_111, 1'b1);
    checks++; if (done !== 1'b1 || pat_cnt !== 8'h01 || fail_cnt !== 8'h00) begin failures++; $display("FAIL midrst_rerun got=%b %h %h exp=1 01 00", done, pat_cnt, fail_cnt); end
    tick();
  endtask

  task automatic test_back_to_back();
    begin_session();
    for (int i = 0; i < 256; i++) run_pattern(3'b011, 2'b11, 5'b00_000, (i == 255));
    checks++; if (done !== 1'b1 || pat_cnt !== 8'hFF || fail_cnt !== 8'hFF || first_fail !== 8'h00)
      begin failures++; $display("FAIL b2b_sat got=%b %h %h %h exp=1 ff ff 00", done, pat_cnt, fail_cnt, first_fail); end
    tick();
  endtask

  initial begin
    pat_if.pat_valid = 1'b0;
    pat_if.pat_in    = '0;
    pat_if.exp_in    = '0;
    pat_if.pat_last  = 1'b0;
    test_reset();
    test_single();
    test_two_patterns();
    test_stall();
    test_start_with_valid();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
